// File: rtl/seed_g_sched.sv
// rtl/seed_g_sched.sv - iterative SEED G-function scheduler sharing one SS lookup bank between two requesters
// Define SEED_G_SCHED_PRIO_EN for fixed A-over-B priority instead of round-robin arbitration.
module seed_g_sched #(
  parameter int SS_LAT = 0
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_ReqA_Valid,
  output logic        o_ReqA_Ready,
  input  logic [31:0] i_ReqA_Data,
  output logic        o_RspA_Valid,
  output logic [31:0] o_RspA_Data,
  input  logic        i_ReqB_Valid,
  output logic        o_ReqB_Ready,
  input  logic [31:0] i_ReqB_Data,
  output logic        o_RspB_Valid,
  output logic [31:0] o_RspB_Data,
  output logic [1:0]  o_SS_Sel,
  output logic [7:0]  o_SS_Byte,
  input  logic [31:0] i_SS_Word
);
  typedef enum logic [1:0] {S_IDLE, S_LOOK, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] x;
  logic [31:0] acc;
  logic [31:0] acc_nx;
  logic        owner;
  logic        grant_a;
  logic        grant_b;
  logic        sample;
  logic        finish;
  logic        idle;

  assign idle = (state == S_IDLE) && !i_Rst;

`ifdef SEED_G_SCHED_PRIO_EN
  assign grant_a = i_ReqA_Valid;
  assign grant_b = i_ReqB_Valid && !i_ReqA_Valid;
`else
  // favour_b set means A was served last, so B wins the next tie
  logic favour_b;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      favour_b <= 1'b0;
    end else if (o_ReqA_Ready || o_ReqB_Ready) begin
      favour_b <= o_ReqA_Ready;
    end
  end

  assign grant_a = i_ReqA_Valid && !(i_ReqB_Valid && favour_b);
  assign grant_b = i_ReqB_Valid && !(i_ReqA_Valid && !favour_b);
`endif

  assign o_ReqA_Ready = idle && grant_a;
  assign o_ReqB_Ready = idle && grant_b;

  assign o_SS_Sel  = (state == S_LOOK) ? cnt : 2'd0;
  assign o_SS_Byte = (state == S_LOOK) ? x[{cnt, 3'b000} +: 8] : 8'd0;

  // With a registered bank each word arrives one cycle after its issue
  always_comb begin
    if (SS_LAT == 0) begin
      sample = (state == S_LOOK);
      finish = (state == S_LOOK) && (cnt == 2'd3);
    end else begin
      sample = ((state == S_LOOK) && (cnt != 2'd0)) || (state == S_WAIT);
      finish = (state == S_WAIT);
    end
  end

  assign acc_nx = sample ? (acc ^ i_SS_Word) : acc;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= S_IDLE;
      cnt          <= 2'd0;
      x            <= 32'd0;
      acc          <= 32'd0;
      owner        <= 1'b0;
      o_RspA_Valid <= 1'b0;
      o_RspA_Data  <= 32'd0;
      o_RspB_Valid <= 1'b0;
      o_RspB_Data  <= 32'd0;
    end else begin
      o_RspA_Valid <= 1'b0;
      o_RspB_Valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (o_ReqA_Ready || o_ReqB_Ready) begin
            owner <= o_ReqB_Ready;
            x     <= o_ReqB_Ready ? i_ReqB_Data : i_ReqA_Data;
            acc   <= 32'd0;
            cnt   <= 2'd0;
            state <= S_LOOK;
          end
        end
        S_LOOK: begin
          acc <= acc_nx;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= (SS_LAT == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          acc   <= acc_nx;
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      // Response registers load on the edge into DONE so the pulse lines up with it
      if (finish) begin
        if (owner) begin
          o_RspB_Valid <= 1'b1;
          o_RspB_Data  <= acc_nx;
        end else begin
          o_RspA_Valid <= 1'b1;
          o_RspA_Data  <= acc_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seed_g_sched.sv
// tb/tb_seed_g_sched.sv - self-checking bench for seed_g_sched with combinational and registered SS bank stubs
module tb_seed_g_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // SS_LAT=0 instance
  logic        va = 1'b0, vb = 1'b0;
  logic [31:0] da = 32'd0, db = 32'd0;
  logic        rdy_a, rdy_b, rva, rvb;
  logic [31:0] rda, rdb, word;
  logic [1:0]  sel;
  logic [7:0]  byt;
  bit          full0 = 1'b0;

  // SS_LAT=1 instance
  logic        va1 = 1'b0, vb1 = 1'b0;
  logic [31:0] da1 = 32'd0, db1 = 32'd0;
  logic        rdy1_a, rdy1_b, rva1, rvb1;
  logic [31:0] rda1, rdb1;
  logic [31:0] word1 = 32'd0;
  logic [1:0]  sel1;
  logic [7:0]  byt1;
  bit          full1 = 1'b0;

  // Reference model state
  bit          last_b = 1'b1;
  logic [31:0] held_a = 32'd0, held_b = 32'd0;
  logic [31:0] held1_a = 32'd0, held1_b = 32'd0;

  seed_g_sched #(.SS_LAT(0)) u0 (
    .i_Clk(clk), .i_Rst(rst),
    .i_ReqA_Valid(va), .o_ReqA_Ready(rdy_a), .i_ReqA_Data(da),
    .o_RspA_Valid(rva), .o_RspA_Data(rda),
    .i_ReqB_Valid(vb), .o_ReqB_Ready(rdy_b), .i_ReqB_Data(db),
    .o_RspB_Valid(rvb), .o_RspB_Data(rdb),
    .o_SS_Sel(sel), .o_SS_Byte(byt), .i_SS_Word(word)
  );

  seed_g_sched #(.SS_LAT(1)) u1 (
    .i_Clk(clk), .i_Rst(rst),
    .i_ReqA_Valid(va1), .o_ReqA_Ready(rdy1_a), .i_ReqA_Data(da1),
    .o_RspA_Valid(rva1), .o_RspA_Data(rda1),
    .i_ReqB_Valid(vb1), .o_ReqB_Ready(rdy1_b), .i_ReqB_Data(db1),
    .o_RspB_Valid(rvb1), .o_RspB_Data(rdb1),
    .o_SS_Sel(sel1), .o_SS_Byte(byt1), .i_SS_Word(word1)
  );

  // S-box stub: exact SEED S1 values at the bytes the directed cases use
  function automatic logic [7:0] s1_byte(input logic [7:0] b);
    case (b)
      8'h00:   return 8'hA9;
      8'h01:   return 8'h85;
      8'h5A:   return 8'h00;
      8'h8D:   return 8'h80;
      8'hFF:   return 8'h9A;
      default: return (b * 8'h1D) ^ 8'h47;
    endcase
  endfunction

  function automatic logic [31:0] ss_word(input logic [1:0] s, input logic [7:0] b, input bit full);
    logic [7:0] t;
    t = s1_byte(b);
    if (s == 2'd0) return {t & 8'h3F, t & 8'hCF, t & 8'hF3, t & 8'hFC};
    if (!full) return 32'd0;
    return {b ^ 8'h5C, b + {6'd0, s}, ~b ^ {s, s, s, s}, 8'hC3 ^ {s, 6'd0}};
  endfunction

  function automatic logic [31:0] g_model(input logic [31:0] xv, input bit full);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) r = r ^ ss_word(i[1:0], xv[8*i +: 8], full);
    return r;
  endfunction

  assign word = ss_word(sel, byt, full0);
  always_ff @(posedge clk) word1 <= ss_word(sel1, byt1, full1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_b  = 1'b1;
    held_a  = 32'd0;
    held_b  = 32'd0;
    held1_a = 32'd0;
    held1_b = 32'd0;
  endtask

  // One full transaction on u0; inputs must already be driven in the IDLE cycle
  task automatic run_op0(input bit full, input bit scramble, output bit owner);
    logic [31:0] xv, exp;
    #1;
    full0 = full;
`ifdef SEED_G_SCHED_PRIO_EN
    owner = !va;
`else
    owner = (va && vb) ? !last_b : vb;
`endif
    xv  = owner ? db : da;
    exp = g_model(xv, full);
    checks++;
    if ({rdy_a, rdy_b} !== {!owner, owner}) begin
      failures++;
      $display("FAIL ready_grant: got a=%b b=%b, want a=%b b=%b", rdy_a, rdy_b, !owner, owner);
    end
    tick();
    last_b = owner;
    if (scramble) begin
      if (owner) begin vb = 1'($urandom_range(0, 1)); db = $urandom; end
      else       begin va = 1'($urandom_range(0, 1)); da = $urandom; end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({sel, byt, rdy_a, rdy_b, rva, rvb, rda, rdb} !==
          {k[1:0], xv[8*k +: 8], 4'b0000, held_a, held_b}) begin
        failures++;
        $display("FAIL lookup_%0d: got sel=%0d byte=%h rdy=%b%b rsp=%b%b da=%h db=%h, want sel=%0d byte=%h rdy=00 rsp=00 da=%h db=%h",
                 k, sel, byt, rdy_a, rdy_b, rva, rvb, rda, rdb, k, xv[8*k +: 8], held_a, held_b);
      end
      tick();
    end
    if (owner) held_b = exp; else held_a = exp;
    checks++;
    if ({rva, rvb, rda, rdb, rdy_a, rdy_b, sel, byt} !== {!owner, owner, held_a, held_b, 2'b00, 2'd0, 8'd0}) begin
      failures++;
      $display("FAIL response: got v=%b%b da=%h db=%h rdy=%b%b sel=%0d, want v=%b%b da=%h db=%h rdy=00 sel=0",
               rva, rvb, rda, rdb, rdy_a, rdy_b, sel, !owner, owner, held_a, held_b);
    end
    tick();
    checks++;
    if ({rva, rvb, rda, rdb} !== {2'b00, held_a, held_b}) begin
      failures++;
      $display("FAIL response_hold: got v=%b%b da=%h db=%h, want v=00 da=%h db=%h",
               rva, rvb, rda, rdb, held_a, held_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    va = 1'b1; vb = 1'b1; da = 32'h1111_2222; db = 32'h3333_4444;
    va1 = 1'b1; vb1 = 1'b1;
    tick();
    tick();
    checks++;
    if ({rdy_a, rdy_b, rva, rvb, rda, rdb, sel, byt} !== 76'd0) begin
      failures++;
      $display("FAIL reset_u0: got rdy=%b%b v=%b%b da=%h db=%h sel=%0d byte=%h, want all 0",
               rdy_a, rdy_b, rva, rvb, rda, rdb, sel, byt);
    end
    checks++;
    if ({rdy1_a, rdy1_b, rva1, rvb1, rda1, rdb1, sel1, byt1} !== 76'd0) begin
      failures++;
      $display("FAIL reset_u1: got rdy=%b%b v=%b%b da=%h db=%h sel=%0d byte=%h, want all 0",
               rdy1_a, rdy1_b, rva1, rvb1, rda1, rdb1, sel1, byt1);
    end
    va = 1'b0; vb = 1'b0; va1 = 1'b0; vb1 = 1'b0;
    rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if ({rdy_a, rdy_b} !== 2'b00) begin
      failures++;
      $display("FAIL idle_no_valid: got rdy=%b%b, want 00", rdy_a, rdy_b);
    end
  endtask

  task automatic test_a_only();
    bit o;
    va = 1'b1; da = 32'h0000_0000; vb = 1'b0;
    run_op0(1'b0, 1'b0, o);
    va = 1'b0;
    checks++;
    if (rda !== 32'h2989_a1a8) begin
      failures++;
      $display("FAIL a_only_data: got %h, want 2989a1a8", rda);
    end
  endtask

  task automatic test_b_only();
    bit o;
    vb = 1'b1; db = 32'h1234_56FF; va = 1'b0;
    run_op0(1'b0, 1'b0, o);
    vb = 1'b0;
    checks++;
    if (rdb !== 32'h1a8a_9298) begin
      failures++;
      $display("FAIL b_only_data: got %h, want 1a8a9298", rdb);
    end
  endtask

  task automatic test_arbitration();
    bit o;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    va = 1'b1; da = 32'h0000_005A;
    vb = 1'b1; db = 32'h0000_0001;
    for (int i = 0; i < 3; i++) run_op0(1'b0, 1'b0, o);
    va = 1'b0; vb = 1'b0;
  endtask

  task automatic test_random();
    bit o;
    for (int i = 0; i < 40; i++) begin
      if (!va) begin va = 1'($urandom_range(0, 1)); da = $urandom; end
      if (!vb) begin vb = 1'($urandom_range(0, 1)); db = $urandom; end
      if (!va && !vb) begin
        #1;
        checks++;
        if ({rdy_a, rdy_b, rva, rvb} !== 4'b0000) begin
          failures++;
          $display("FAIL idle_gap: got rdy=%b%b v=%b%b, want 0000", rdy_a, rdy_b, rva, rvb);
        end
        tick();
      end else begin
        run_op0(1'b1, 1'b1, o);
      end
    end
    va = 1'b0; vb = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    bit o;
    va = 1'b1; da = $urandom; vb = 1'b0;
    full0 = 1'b1;
    #1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({rdy_a, rdy_b, rva, rvb, rda, rdb, sel, byt} !== 76'd0) begin
      failures++;
      $display("FAIL mid_op_reset: got rdy=%b%b v=%b%b da=%h db=%h sel=%0d byte=%h, want all 0",
               rdy_a, rdy_b, rva, rvb, rda, rdb, sel, byt);
    end
    model_reset();
    tick();
    rst = 1'b0;
    va = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({rva, rvb, sel} !== 4'b0000) begin
        failures++;
        $display("FAIL no_rsp_after_abort_%0d: got v=%b%b sel=%0d, want v=00 sel=0", i, rva, rvb, sel);
      end
      tick();
    end
    va = 1'b1; da = $urandom;
    run_op0(1'b1, 1'b0, o);
    va = 1'b0;
  endtask

  // Registered bank: one extra WAIT cycle before the response
  task automatic run_op1(input bit is_b, input logic [31:0] xv, input bit full);
    logic [31:0] exp;
    full1 = full;
    exp = g_model(xv, full);
    if (is_b) begin vb1 = 1'b1; db1 = xv; end
    else      begin va1 = 1'b1; da1 = xv; end
    #1;
    checks++;
    if ({rdy1_a, rdy1_b} !== {!is_b, is_b}) begin
      failures++;
      $display("FAIL l1_ready_grant: got a=%b b=%b, want a=%b b=%b", rdy1_a, rdy1_b, !is_b, is_b);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({sel1, byt1, rdy1_a, rdy1_b, rva1, rvb1} !== {k[1:0], xv[8*k +: 8], 4'b0000}) begin
        failures++;
        $display("FAIL l1_lookup_%0d: got sel=%0d byte=%h rdy=%b%b v=%b%b, want sel=%0d byte=%h rdy=00 v=00",
                 k, sel1, byt1, rdy1_a, rdy1_b, rva1, rvb1, k, xv[8*k +: 8]);
      end
      tick();
    end
    checks++;
    if ({sel1, byt1, rdy1_a, rdy1_b, rva1, rvb1} !== 14'd0) begin
      failures++;
      $display("FAIL l1_wait: got sel=%0d byte=%h rdy=%b%b v=%b%b, want all 0",
               sel1, byt1, rdy1_a, rdy1_b, rva1, rvb1);
    end
    tick();
    if (is_b) held1_b = exp; else held1_a = exp;
    checks++;
    if ({rva1, rvb1, rda1, rdb1, rdy1_a, rdy1_b} !== {!is_b, is_b, held1_a, held1_b, 2'b00}) begin
      failures++;
      $display("FAIL l1_response: got v=%b%b da=%h db=%h rdy=%b%b, want v=%b%b da=%h db=%h rdy=00",
               rva1, rvb1, rda1, rdb1, rdy1_a, rdy1_b, !is_b, is_b, held1_a, held1_b);
    end
    tick();
    #1;
    checks++;
    if ({rva1, rvb1, rdy1_a, rdy1_b} !== {2'b00, !is_b, is_b}) begin
      failures++;
      $display("FAIL l1_after_done: got v=%b%b rdy=%b%b, want v=00 rdy=%b%b",
               rva1, rvb1, rdy1_a, rdy1_b, !is_b, is_b);
    end
    va1 = 1'b0; vb1 = 1'b0;
    tick();
  endtask

  task automatic test_lat1();
    run_op1(1'b0, 32'h0000_008D, 1'b0);
    checks++;
    if (rda1 !== 32'h0080_8080) begin
      failures++;
      $display("FAIL l1_directed_data: got %h, want 00808080", rda1);
    end
    for (int i = 0; i < 6; i++) run_op1(1'($urandom_range(0, 1)), $urandom, 1'b1);
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_only();
    test_arbitration();
    test_random();
    test_reset_mid_op();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seed_g_sched.md
Name: seed_g_sched

Overview:
Iterative SEED G-function scheduler. Two requesters share one external SS lookup bank (SS0..SS3, selected by index): A is the round F-function and B is the key schedule. The block arbitrates between them and issues four byte lookups in sequence, one per cycle. It XOR-accumulates the returned words into G(X) = SS3[X3]^SS2[X2]^SS1[X1]^SS0[X0] and returns the result to the winning requester. It sits between the SEED128 round/key-schedule control and the SS table bank.

Parameters:
SS_LAT, 0, lookup latency of the SS bank in cycles; 0 = combinational return, 1 = registered return. Other values unsupported.

Ports:
i_Clk  input  1  clock
i_Rst  input  1  reset, asynchronous, active-high
i_ReqA_Valid  input  1  requester A has an operand
o_ReqA_Ready  output  1  A may be accepted this cycle
i_ReqA_Data  input  32  operand X from A
o_RspA_Valid  output  1  one-cycle pulse, result for A
o_RspA_Data  output  32  G(X) for A
i_ReqB_Valid  input  1  requester B has an operand
o_ReqB_Ready  output  1  B may be accepted this cycle
i_ReqB_Data  input  32  operand X from B
o_RspB_Valid  output  1  one-cycle pulse, result for B
o_RspB_Data  output  32  G(X) for B
o_SS_Sel  output  2  table select, 0..3 = SS0..SS3
o_SS_Byte  output  8  lookup index
i_SS_Word  input  32  table output

Behaviour:
- Clock and reset: single clock i_Clk. i_Rst is asynchronous and active-high.
- Reset values: all outputs 0; FSM IDLE; accumulator 0; round-robin pointer favours A.
- FSM states: IDLE -> LOOK -> (WAIT, only when SS_LAT=1) -> DONE -> IDLE.
- IDLE:
  - Ready is asserted only in IDLE, and only to the granted requester. The other requester's ready is 0.
  - Grant when both are valid: round-robin; the requester not served last wins.
  - Grant when one is valid: that requester.
  - Grant is a combinational function of the valids and the pointer.
  - Accept when valid&&ready: latch X and the owner ID; clear the accumulator; update the pointer to the owner; go to LOOK with cnt=0.
- LOOK:
  - Each cycle drive o_SS_Sel=cnt and o_SS_Byte=X[8*cnt+7:8*cnt]; increment cnt.
  - After cnt=3: go to DONE if SS_LAT=0, or to WAIT if SS_LAT=1.
  - Outside LOOK, o_SS_Sel and o_SS_Byte hold 0.
- Accumulation:
  - SS_LAT=0: acc ^= i_SS_Word in the same cycle as each issue.
  - SS_LAT=1: acc ^= i_SS_Word one cycle after each issue. WAIT covers the last sample.
- DONE:
  - Pulse the owner's o_RspX_Valid for exactly 1 cycle; o_RspX_Data = acc.
  - The other requester's response valid stays 0.
  - Response data is held until the next DONE for that requester.
  - There is no response backpressure; the requester must consume the result in the DONE cycle.
- Latency: accept in cycle T; lookups in T+1..T+4; response in T+5 (SS_LAT=0) or T+6 (SS_LAT=1).
- Throughput: one G per 6 (SS_LAT=0) or 7 (SS_LAT=1) cycles. The next accept is possible the cycle after DONE.
- Request inputs are ignored outside IDLE. A requester holds valid and data until it sees ready.
- Reset mid-operation: the operation is aborted immediately and no response is issued. Outputs return to reset values asynchronously.
- A valid deasserted before grant is legal; nothing is accepted.

Optional Feature:
SEED_G_SCHED_PRIO_EN:
- Defined: fixed priority, A always wins when both are valid; the round-robin pointer is removed.
- Undefined: round-robin as specified above.

Test Plan:
- SS bank stub: SS0 table for sel=0, 0 for sel 1..3; SS_LAT=0.
- A only, X=0x00000000 -> o_SS_Sel 0,1,2,3 / o_SS_Byte 00,00,00,00 in T+1..T+4 -> o_RspA_Valid at T+5, o_RspA_Data=0x2989a1a8; B response never asserted.
- B only, X=0x123456FF -> o_SS_Byte sequence FF,56,34,12 -> o_RspB_Data=0x1a8a9298 at T+5.
- A and B valid together from reset, A X=0x0000005A, B X=0x00000001 -> A served first (0x00000000), then B (0x05858184). With both still valid, the next grant alternates back to A. With SEED_G_SCHED_PRIO_EN defined, A is granted again instead.
- SS_LAT=1, registered stub, A X=0x0000008D -> response at T+6, data 0x00808080, WAIT state visible; ready low from T+1 through T+6.
- i_Rst pulsed during LOOK (cycle T+2) -> all outputs 0 immediately, no response pulse. The next request after reset completes normally with correct data.
